// File: rtl/dmem_bus_arbiter.sv
// Two-port round-robin arbiter for the data-memory bus.
// One transaction in flight: latch request, issue for one cycle, wait out the
// fixed read latency, then pulse the winner's ack. Every output comes from
// state or registers, so there is no input-to-output combinational path.
module dmem_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  output logic        m0_ack,
  output logic [31:0] m0_read_data,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  output logic        m1_ack,
  output logic [31:0] m1_read_data,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  output logic [3:0]  bus_byte_enable,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic              gnt;
  logic              last_grant;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        cnt;
  logic [1:0][31:0]  rd_q;

  logic [1:0]        req;
  logic              nxt_gnt;
  logic              issue;

  assign req = {m1_req, m0_req};

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    nxt_gnt = 1'b0;
    case (req)
      2'b01:   nxt_gnt = 1'b0;
      2'b10:   nxt_gnt = 1'b1;
      2'b11:   nxt_gnt = ~last_grant;
      default: nxt_gnt = 1'b0;
    endcase
  end

  // Arbitration FSM with latched payload, read-latency counter and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt        <= '0;
      rd_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= nxt_gnt;
            wr_q    <= nxt_gnt ? m1_write       : m0_write;
            addr_q  <= nxt_gnt ? m1_address     : m0_address;
            wdata_q <= nxt_gnt ? m1_write_data  : m0_write_data;
            be_q    <= nxt_gnt ? m1_byte_enable : m0_byte_enable;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_q) begin
            state <= DONE;
          end else begin
            cnt   <= 3'(READ_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rd_q[gnt] <= bus_read_data;
            state     <= DONE;
          end
        end
        DONE: begin
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus is driven only during the single issue cycle; zero otherwise.
  assign issue            = (state == ISSUE);
  assign bus_address      = issue ? addr_q  : '0;
  assign bus_write_data   = issue ? wdata_q : '0;
  assign bus_byte_enable  = issue ? be_q    : '0;
  assign bus_write_enable = issue &  wr_q;
  assign bus_read_enable  = issue & ~wr_q;

  assign m0_ack       = (state == DONE) & ~gnt;
  assign m1_ack       = (state == DONE) &  gnt;
  assign m0_read_data = rd_q[0];
  assign m1_read_data = rd_q[1];

endmodule
